tx_sample_unpacker: RTL and testbench
=====================================

TX_SAMPLE_UNPACKER -- requirements
Module: tx_sample_unpacker

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample word width.
REQ-002 SHALL have parameter MAXCHAN, default 4, number of output channels.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port: clock  in  1  master clock (clk64 domain).
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: enable  in  1  enable_tx from master_control.
REQ-007 SHALL have port: numchan  in  3  active channels; 0 is treated as 1, values >4 as 4.
REQ-008 SHALL have port: strobe_in  in  1  one-cycle sample-rate strobe (strobe_interp).
REQ-009 SHALL have port: fifo_data  in  16  TX FIFO output; registered, valid one cycle after rdreq.
REQ-010 SHALL have port: fifo_usedw  in  12  words currently in TX FIFO.
REQ-011 SHALL have port: fifo_rdreq  out  1  FIFO read request.
REQ-012 SHALL have ports: ch_0..ch_3  out  16 each  per-channel samples for DAC mux.
REQ-013 SHALL have port: strobe_out  out  1  one-cycle pulse when ch_* update.
REQ-014 SHALL have port: tx_underrun  out  1  sticky underrun flag (drives FX2_3).
REQ-015 SHALL have port: clear_status  in  1  clears tx_underrun.

Function
REQ-016 SHALL implement states IDLE, READ and WAIT.
REQ-017 In IDLE, when strobe_in=1, enable=1 and fifo_usedw >= n (clamped numchan), SHALL latch n, clear the word counter and enter READ.
REQ-018 In IDLE, when strobe_in=1, enable=1 and fifo_usedw < n, SHALL set tx_underrun, perform no reads, load all ch_* with 0 and pulse strobe_out in the next cycle.
REQ-019 In READ, SHALL assert fifo_rdreq for exactly n consecutive cycles, then enter WAIT.
REQ-020 Word k (k = 0..n-1) SHALL be captured into staging register k one cycle after its rdreq.
REQ-021 In WAIT, SHALL capture the last word, then return to IDLE.
REQ-022 Staging registers SHALL transfer to ch_* atomically, with strobe_out=1, in cycle T+n+2, where T is the strobe_in cycle.
REQ-023 Channels with index >= n SHALL output 0.
REQ-024 Interleave order SHALL be: first word -> ch_0, second word -> ch_1, and so on.
REQ-025 Between updates, ch_* SHALL hold their values.
REQ-026 A strobe_in while in READ or WAIT SHALL be ignored for data purposes and SHALL set tx_underrun.
REQ-027 The minimum legal strobe period SHALL be n+3 cycles.
REQ-028 numchan changes SHALL take effect only at the next frame start.
REQ-029 If enable deasserts in READ or WAIT, the block SHALL return to IDLE on the next cycle with fifo_rdreq=0, ch_*=0 and no strobe_out; words already read are discarded.
REQ-030 clear_status=1 SHALL clear tx_underrun; when a set and a clear occur in the same cycle, set SHALL win.
REQ-031 fifo_rdreq SHALL never be asserted outside READ.
REQ-032 The number of reads per frame SHALL equal n exactly, so channel alignment is preserved.

Reset
REQ-033 On reset, the block SHALL go to IDLE immediately.
REQ-034 On reset, fifo_rdreq, strobe_out, tx_underrun, ch_0..ch_3, staging registers, counter and latched n SHALL all be 0.
REQ-035 A reset asserted mid-frame SHALL abort the frame with no further reads.

Structure
REQ-036 State encodings, MAXCHAN and WIDTH defaults SHALL reside in the shared mrfm.vh header.
REQ-037 One sub-module, tx_stage_regs (staging bank with atomic transfer and zero-fill), SHALL be used; all other logic SHALL stay flat.

Verification
REQ-038 n=1, usedw=5, fifo words 0x1234, strobe at T -> rdreq at T+1 only; ch_0=0x1234, ch_1..ch_3=0, strobe_out at T+3.
REQ-039 n=4, words 0xA000..0xA003 -> rdreq T+1..T+4; ch_0..ch_3=0xA000..0xA003 and strobe_out at T+6; no underrun.
REQ-040 n=2, usedw=1, strobe -> no rdreq, tx_underrun=1, ch_*=0, strobe_out at T+1; later clear_status -> tx_underrun=0.
REQ-041 n=4, second strobe at T+3 -> tx_underrun=1, still exactly 4 reads, frame delivered at T+6.
REQ-042 enable dropped at T+2 (n=4) -> rdreq low from T+3, ch_*=0, no strobe_out; reset pulse mid-frame -> all outputs 0 immediately.
REQ-043 clear_status coincident with an underrun -> tx_underrun remains 1.

Source files
------------

// File: rtl/tx_sample_unpacker_pkg.sv
// Shared defaults, state encoding and channel-count helper for the TX sample unpacker.
package tx_sample_unpacker_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int MAXCHAN_DEF = 4;
    localparam int NUM_PORTS   = 4;
    localparam int IDX_W       = 2;
    localparam int NCH_W       = 3;
    localparam int USEDW_W     = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // A request of 0 channels still moves one word; requests above the bank size saturate.
    function automatic logic [NCH_W-1:0] clamp_chan(input logic [NCH_W-1:0] req,
                                                    input logic [NCH_W-1:0] max_n);
        logic [NCH_W-1:0] n;
        n = (req == 3'd0) ? 3'd1 : req;
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/tx_sample_unpacker_if.sv
// Bundle between the unpacker, its TX FIFO and the DAC channel mux.
interface tx_sample_unpacker_if
    import tx_sample_unpacker_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic [WIDTH-1:0]   fifo_data;
    logic [USEDW_W-1:0] fifo_usedw;
    logic               fifo_rdreq;
    logic [WIDTH-1:0]   ch_0;
    logic [WIDTH-1:0]   ch_1;
    logic [WIDTH-1:0]   ch_2;
    logic [WIDTH-1:0]   ch_3;
    logic               strobe_out;

    modport master (
        input  fifo_data, fifo_usedw,
        output fifo_rdreq, ch_0, ch_1, ch_2, ch_3, strobe_out
    );

    modport slave (
        output fifo_data, fifo_usedw,
        input  fifo_rdreq, ch_0, ch_1, ch_2, ch_3, strobe_out
    );

endinterface

// File: rtl/tx_sample_unpacker_stage_regs.sv
// Staging bank: collects one frame of words and moves them to the channel outputs
// in a single cycle, zero-filling channels beyond the frame width.
module tx_stage_regs
    import tx_sample_unpacker_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cap_en,
    input  logic [IDX_W-1:0] cap_idx,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             xfer,
    input  logic [NCH_W-1:0] xfer_n,
    input  logic             zero,
    output logic [WIDTH-1:0] ch [NUM_PORTS]
);

    logic [WIDTH-1:0] stage_q [NUM_PORTS];
    logic [WIDTH-1:0] stage_d [NUM_PORTS];
    logic [WIDTH-1:0] ch_q    [NUM_PORTS];
    logic [WIDTH-1:0] ch_d    [NUM_PORTS];

    // Next bank state; a transfer sees the word captured in the same cycle.
    always_comb begin
        stage_d = stage_q;
        ch_d    = ch_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (zero) begin
                stage_d[k] = '0;
                ch_d[k]    = '0;
            end else begin
                stage_d[k] = (cap_en && (cap_idx == IDX_W'(k))) ? cap_data : stage_q[k];
                if (xfer) begin
                    ch_d[k] = (k < int'(xfer_n)) ? stage_d[k] : '0;
                end else begin
                    ch_d[k] = ch_q[k];
                end
            end
        end
    end

    // Bank and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                stage_q[k] <= '0;
                ch_q[k]    <= '0;
            end
        end else begin
            stage_q <= stage_d;
            ch_q    <= ch_d;
        end
    end

    assign ch = ch_q;

endmodule

// File: rtl/tx_sample_unpacker.sv
// Pulls n interleaved samples from the TX FIFO on every sample strobe and presents
// them on per-channel outputs; flags an underrun when a frame cannot be served.
module tx_sample_unpacker
    import tx_sample_unpacker_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MAXCHAN = MAXCHAN_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [NCH_W-1:0] numchan,
    input  logic             strobe_in,
    input  logic             clear_status,
    output logic             tx_underrun,
    tx_sample_unpacker_if.master bus
);

    localparam logic [NCH_W-1:0] MAX_N =
        (MAXCHAN > NUM_PORTS) ? NCH_W'(NUM_PORTS) : NCH_W'(MAXCHAN);

    state_t           state_q, state_d;
    logic [NCH_W-1:0] n_q, n_d;
    logic [NCH_W-1:0] cnt_q, cnt_d;
    logic             rdreq_q, rdreq_d;
    logic             strobe_out_q, strobe_out_d;
    logic             tx_underrun_q, tx_underrun_d;

    logic [NCH_W-1:0] n_req_s;
    logic             set_un_s;
    logic             cap_en_s;
    logic [IDX_W-1:0] cap_idx_s;
    logic             xfer_s;
    logic             zero_s;
    logic [WIDTH-1:0] ch_s [NUM_PORTS];

    assign n_req_s = clamp_chan(numchan, MAX_N);

    // Frame sequencing: cnt_q is the index of the read issued this cycle, so the word
    // arriving now (one cycle behind its read) belongs to slot cnt_q-1.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        rdreq_d      = 1'b0;
        strobe_out_d = 1'b0;
        set_un_s     = 1'b0;
        cap_en_s     = 1'b0;
        cap_idx_s    = IDX_W'(cnt_q - 3'd1);
        xfer_s       = 1'b0;
        zero_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strobe_in && enable) begin
                    if (bus.fifo_usedw >= USEDW_W'(n_req_s)) begin
                        state_d = ST_READ;
                        n_d     = n_req_s;
                        cnt_d   = 3'd0;
                        rdreq_d = 1'b1;
                    end else begin
                        set_un_s     = 1'b1;
                        zero_s       = 1'b1;
                        strobe_out_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                set_un_s = strobe_in;
                if (!enable) begin
                    state_d = ST_IDLE;
                    zero_s  = 1'b1;
                end else begin
                    cap_en_s = (cnt_q != 3'd0);
                    if (cnt_q == (n_q - 3'd1)) begin
                        state_d = ST_WAIT;
                    end else begin
                        rdreq_d = 1'b1;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            ST_WAIT: begin
                set_un_s = strobe_in;
                if (!enable) begin
                    state_d = ST_IDLE;
                    zero_s  = 1'b1;
                end else begin
                    cap_en_s     = 1'b1;
                    cap_idx_s    = IDX_W'(n_q - 3'd1);
                    xfer_s       = 1'b1;
                    strobe_out_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                zero_s  = 1'b1;
            end
        endcase
        tx_underrun_d = set_un_s ? 1'b1 : (clear_status ? 1'b0 : tx_underrun_q);
    end

    // Control and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            n_q           <= 3'd0;
            cnt_q         <= 3'd0;
            rdreq_q       <= 1'b0;
            strobe_out_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            cnt_q         <= cnt_d;
            rdreq_q       <= rdreq_d;
            strobe_out_q  <= strobe_out_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    tx_stage_regs #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clock    (clock),
        .reset    (reset),
        .cap_en   (cap_en_s),
        .cap_idx  (cap_idx_s),
        .cap_data (bus.fifo_data),
        .xfer     (xfer_s),
        .xfer_n   (n_q),
        .zero     (zero_s),
        .ch       (ch_s)
    );

    assign bus.fifo_rdreq = rdreq_q;
    assign bus.strobe_out = strobe_out_q;
    assign bus.ch_0       = ch_s[0];
    assign bus.ch_1       = ch_s[1];
    assign bus.ch_2       = ch_s[2];
    assign bus.ch_3       = ch_s[3];
    assign tx_underrun    = tx_underrun_q;

endmodule

// File: tb/tb_tx_sample_unpacker.sv
// Directed bench: a table of single-frame vectors plus hand-written multi-cycle sequences.
module tb_tx_sample_unpacker;
    import tx_sample_unpacker_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] numchan;
    logic       strobe_in;
    logic       clear_status;
    logic       tx_underrun;

    always #5 clock = ~clock;

    tx_sample_unpacker_if bus ();

    tx_sample_unpacker dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .numchan      (numchan),
        .strobe_in    (strobe_in),
        .clear_status (clear_status),
        .tx_underrun  (tx_underrun),
        .bus          (bus)
    );

    // Registered-output FIFO: data appears the cycle after the read request.
    logic [15:0] fifo_mem [256];
    int unsigned rd_ptr = 0;
    always @(posedge clock) begin
        if (bus.fifo_rdreq) begin
            bus.fifo_data <= fifo_mem[rd_ptr[7:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    typedef struct packed {
        logic [2:0]       numchan;
        logic [11:0]      usedw;
        logic [3:0][15:0] w;       // FIFO words, w[0] read first
        logic [3:0][15:0] ec;      // expected ch_3..ch_0
        logic [3:0]       ereads;
        logic [3:0]       eso;     // strobe_out cycle relative to strobe_in
        logic             eun;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    int n_vec  = 0;
    int n_miss = 0;
    int rd_n, rd_first, rd_last, so_n, so_at;
    logic [3:0][15:0] so_ch;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][15:0] ch_now();
        return {bus.ch_3, bus.ch_2, bus.ch_1, bus.ch_0};
    endfunction

    task automatic check_ch(input string tag, input logic [3:0][15:0] act,
                            input logic [3:0][15:0] exp);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s ch_%0d", tag, k), int'(act[k]), int'(exp[k]));
        end
    endtask

    task automatic sample(input int c);
        if (bus.fifo_rdreq) begin
            rd_n++;
            if (rd_first < 0) rd_first = c;
            rd_last = c;
        end
        if (bus.strobe_out) begin
            so_n++;
            so_at = c;
            so_ch = ch_now();
        end
    endtask

    task automatic start_frame(input logic [2:0] nc, input logic [11:0] uw,
                               input logic [3:0][15:0] w);
        numchan        = nc;
        bus.fifo_usedw = uw;
        for (int k = 0; k < 4; k++) fifo_mem[8'(rd_ptr + k)] = w[k];
        rd_n = 0; rd_first = -1; rd_last = -1; so_n = 0; so_at = -1; so_ch = '0;
        strobe_in = 1'b1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; numchan = 3'd0; strobe_in = 1'b0; clear_status = 1'b0;
        bus.fifo_usedw = 12'd0;

        vecs[0] = '{3'd1, 12'd5,   {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'h1234},
                    {16'h0000, 16'h0000, 16'h0000, 16'h1234}, 4'd1, 4'd3, 1'b0};
        vecs[1] = '{3'd4, 12'd100, {16'hA003, 16'hA002, 16'hA001, 16'hA000},
                    {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 4'd4, 4'd6, 1'b0};
        vecs[2] = '{3'd2, 12'd1,   {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD},
                    {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 4'd0, 4'd1, 1'b1};
        vecs[3] = '{3'd0, 12'd1,   {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'h0BEE},
                    {16'h0000, 16'h0000, 16'h0000, 16'h0BEE}, 4'd1, 4'd3, 1'b0};
        vecs[4] = '{3'd7, 12'd4,   {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                    {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'd4, 4'd6, 1'b0};
        vecs[5] = '{3'd3, 12'd3,   {16'hDEAD, 16'hC003, 16'hC002, 16'hC001},
                    {16'h0000, 16'hC003, 16'hC002, 16'hC001}, 4'd3, 4'd5, 1'b0};
        vecs[6] = '{3'd2, 12'd2,   {16'hDEAD, 16'hDEAD, 16'hFEED, 16'hD00D},
                    {16'h0000, 16'h0000, 16'hFEED, 16'hD00D}, 4'd2, 4'd4, 1'b0};
        vecs[7] = '{3'd4, 12'd3,   {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD},
                    {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 4'd0, 4'd1, 1'b1};

        repeat (3) tick();
        check("reset rdreq", int'(bus.fifo_rdreq), 0);
        check("reset strobe_out", int'(bus.strobe_out), 0);
        check("reset underrun", int'(tx_underrun), 0);
        check_ch("reset", ch_now(), '0);
        reset = 1'b0; enable = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < NV; i++) begin
            clear_status = 1'b1; tick(); clear_status = 1'b0; tick();
            start_frame(vecs[i].numchan, vecs[i].usedw, vecs[i].w);
            for (int c = 1; c <= 9; c++) begin
                tick();
                strobe_in = 1'b0;
                sample(c);
            end
            check($sformatf("v%0d reads", i), rd_n, int'(vecs[i].ereads));
            check($sformatf("v%0d first rdreq", i), rd_first, (vecs[i].ereads == 4'd0) ? -1 : 1);
            check($sformatf("v%0d last rdreq", i), rd_last,
                  (vecs[i].ereads == 4'd0) ? -1 : int'(vecs[i].ereads));
            check($sformatf("v%0d strobe_out count", i), so_n, 1);
            check($sformatf("v%0d strobe_out cycle", i), so_at, int'(vecs[i].eso));
            check_ch($sformatf("v%0d update", i), so_ch, vecs[i].ec);
            check_ch($sformatf("v%0d hold", i), ch_now(), vecs[i].ec);
            check($sformatf("v%0d underrun", i), int'(tx_underrun), int'(vecs[i].eun));
        end

        // Second strobe mid-frame plus a numchan change that must not affect this frame.
        clear_status = 1'b1; tick(); clear_status = 1'b0; tick();
        start_frame(3'd4, 12'd100, {16'hB003, 16'hB002, 16'hB001, 16'hB000});
        for (int c = 1; c <= 9; c++) begin
            tick();
            strobe_in = (c == 3);
            if (c == 2) numchan = 3'd1;
            sample(c);
        end
        check("dbl-strobe reads", rd_n, 4);
        check("dbl-strobe last rdreq", rd_last, 4);
        check("dbl-strobe strobe_out cycle", so_at, 6);
        check_ch("dbl-strobe", so_ch, {16'hB003, 16'hB002, 16'hB001, 16'hB000});
        check("dbl-strobe underrun", int'(tx_underrun), 1);

        // Enable dropped at T+2.
        tick();
        start_frame(3'd4, 12'd100, {16'h7004, 16'h7003, 16'h7002, 16'h7001});
        for (int c = 1; c <= 9; c++) begin
            tick();
            strobe_in = 1'b0;
            if (c == 2) enable = 1'b0;
            sample(c);
            if (c == 3) check_ch("en-drop", ch_now(), '0);
        end
        enable = 1'b1;
        check("en-drop reads", rd_n, 2);
        check("en-drop last rdreq", rd_last, 2);
        check("en-drop strobe_out count", so_n, 0);

        // Good frame, then a reset in the middle of the next one.
        tick();
        start_frame(3'd2, 12'd100, {16'hDEAD, 16'hDEAD, 16'hA5A5, 16'h5A5A});
        for (int c = 1; c <= 9; c++) begin
            tick();
            strobe_in = 1'b0;
            sample(c);
        end
        check("pre-reset strobe_out cycle", so_at, 4);
        check_ch("pre-reset", ch_now(), {16'h0000, 16'h0000, 16'hA5A5, 16'h5A5A});
        start_frame(3'd4, 12'd100, {16'h9004, 16'h9003, 16'h9002, 16'h9001});
        tick(); strobe_in = 1'b0; tick();
        check("mid-frame rdreq", int'(bus.fifo_rdreq), 1);
        reset = 1'b1;
        #1;
        check("mid-reset rdreq", int'(bus.fifo_rdreq), 0);
        check("mid-reset strobe_out", int'(bus.strobe_out), 0);
        check("mid-reset underrun", int'(tx_underrun), 0);
        check_ch("mid-reset", ch_now(), '0);
        repeat (2) tick();
        reset = 1'b0;
        rd_n = 0; so_n = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            sample(c);
        end
        check("post-reset reads", rd_n, 0);
        check("post-reset strobe_out count", so_n, 0);

        // Underrun set and clear_status in the same cycle: set wins; clear alone clears.
        start_frame(3'd2, 12'd0, {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD});
        clear_status = 1'b1;
        tick();
        strobe_in = 1'b0; clear_status = 1'b0;
        sample(1);
        check("set-wins underrun", int'(tx_underrun), 1);
        check("set-wins strobe_out cycle", so_at, 1);
        check("set-wins reads", rd_n, 0);
        clear_status = 1'b1; tick(); clear_status = 1'b0;
        check("clear underrun", int'(tx_underrun), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
